// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the fetch-stage branch predictor.
// Holds the RV32 opcode constants for the predecoded control-transfer instructions,
// the link register numbers used for return-address-stack hints, the 2-bit counter
// encodings and the saturating counter helper.
package branch_predictor_pkg;

  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcBranch = 7'b1100011;

  localparam logic [4:0] RegRa = 5'd1;
  localparam logic [4:0] RegT0 = 5'd5;

  typedef enum logic [1:0] {
    CntSnt = 2'b00,
    CntWnt = 2'b01,
    CntWt  = 2'b10,
    CntSt  = 2'b11
  } cnt_e;

  function automatic logic is_link(input logic [4:0] r);
    return (r == RegRa) || (r == RegT0);
  endfunction

  // Saturating 2-bit counter step.
  function automatic logic [1:0] cnt_next(input logic [1:0] c, input logic taken);
    logic [1:0] n;
    n = c;
    if (taken) begin
      if (c != CntSt) n = c + 2'd1;
    end else begin
      if (c != CntSnt) n = c - 2'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return address stack.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push, pop    operations; both together replace the top entry (pop then push)
//   push_data    address pushed
//   top          current top entry (valid when !empty)
//   empty        no entries held
// A push when full overwrites the oldest entry; a pop when empty is ignored.
module ras_stack #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [PtrW-1:0] ptr_q;     // next free slot
  logic [PtrW:0]   cnt_q;
  logic [PtrW-1:0] top_idx;
  logic            do_pop;

  assign top_idx = ptr_q - PtrW'(1);
  assign empty   = (cnt_q == '0);
  assign top     = mem_q[top_idx];
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
    end else if (do_pop && push) begin
      // Pop then push collapses to rewriting the top slot.
      mem_q[top_idx] <= push_data;
    end else if (push) begin
      mem_q[ptr_q] <= push_data;
      ptr_q        <= ptr_q + PtrW'(1);
      if (cnt_q != (PtrW + 1)'(DEPTH)) cnt_q <= cnt_q + (PtrW + 1)'(1);
    end else if (do_pop) begin
      ptr_q <= ptr_q - PtrW'(1);
      cnt_q <= cnt_q - (PtrW + 1)'(1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage branch/jump predictor.
// Predecodes jal, jalr and B-type instructions, predicts B-type direction from a
// table of 2-bit saturating counters indexed by pc[log2(BHT_DEPTH)+1:2], and
// computes targets as pc + immediate. Trained by EX-stage resolutions.
// Optional macro BRANCH_PREDICTOR_RAS_EN adds a return address stack that predicts
// jalr returns; without it jalr is always predicted not-taken.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   if_valid, if_stall           fetch qualifiers (stall blocks RAS updates only)
//   if_pc, if_instr              fetched instruction and its PC
//   pred_taken, pred_target      prediction (target = if_pc+4 when not taken)
//   pred_cti                     instruction is jal, jalr or B-type
//   ex_valid, ex_b_type, ex_pc,
//   ex_taken                     resolved outcome used to train the counters
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned BHT_DEPTH = 64,
  parameter int unsigned RAS_DEPTH = 8,
  parameter logic [1:0]  CNT_INIT  = 2'b01
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  input  logic            if_stall,
  input  logic [XLEN-1:0] if_pc,
  input  logic [31:0]     if_instr,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  output logic            pred_cti,
  input  logic            ex_valid,
  input  logic            ex_b_type,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_taken
);

  localparam int unsigned IdxW = $clog2(BHT_DEPTH);

  logic [1:0]      bht_q [BHT_DEPTH];
  logic [IdxW-1:0] if_idx;
  logic [IdxW-1:0] ex_idx;
  logic [1:0]      cnt_upd;

  logic [6:0]      opcode;
  logic [XLEN-1:0] j_imm;
  logic [XLEN-1:0] b_imm;
  logic [XLEN-1:0] pc_plus4;

  assign if_idx   = if_pc[IdxW+1:2];
  assign ex_idx   = ex_pc[IdxW+1:2];
  assign opcode   = if_instr[6:0];
  assign j_imm    = {{(XLEN-20){if_instr[31]}}, if_instr[19:12], if_instr[20],
                     if_instr[30:21], 1'b0};
  assign b_imm    = {{(XLEN-12){if_instr[31]}}, if_instr[7], if_instr[30:25],
                     if_instr[11:8], 1'b0};
  assign pc_plus4 = if_pc + XLEN'(4);

  logic unused_ex_pc;
  assign unused_ex_pc = ^{ex_pc[XLEN-1:IdxW+2], ex_pc[1:0]};

  // ---------------------------------------------------------------------------
  // Counter table: trained only by B-type resolutions. Fetch reads the registered
  // value, so a same-cycle update becomes visible one cycle later.
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_upd = cnt_next(bht_q[ex_idx], ex_taken);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(BHT_DEPTH); i++) bht_q[i] <= CNT_INIT;
    end else if (ex_valid && ex_b_type) begin
      bht_q[ex_idx] <= cnt_upd;
    end
  end

`ifdef BRANCH_PREDICTOR_RAS_EN
  // ---------------------------------------------------------------------------
  // Return address stack, speculatively updated at fetch and never repaired.
  // ---------------------------------------------------------------------------
  logic [4:0]      rd;
  logic [4:0]      rs1;
  logic            is_jal;
  logic            is_jalr;
  logic            is_call;
  logic            is_ret;
  logic            is_swap;
  logic            ras_fire;
  logic            ras_push;
  logic            ras_pop;
  logic [XLEN-1:0] ras_top;
  logic            ras_empty;

  assign rd       = if_instr[11:7];
  assign rs1      = if_instr[19:15];
  assign is_jal   = (opcode == OpcJal);
  assign is_jalr  = (opcode == OpcJalr);
  assign is_call  = (is_jal || is_jalr) && is_link(rd);
  assign is_ret   = is_jalr && is_link(rs1) && (rd == 5'd0);
  // Coroutine swap: both links and distinct -> pop then push.
  assign is_swap  = is_jalr && is_link(rd) && is_link(rs1) && (rd != rs1);
  assign ras_fire = if_valid && !if_stall;
  assign ras_push = ras_fire && is_call;
  assign ras_pop  = ras_fire && (is_ret || is_swap);

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .XLEN  (XLEN)
  ) u_ras_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_plus4),
    .top       (ras_top),
    .empty     (ras_empty)
  );
`else
  logic unused_ras;
  localparam int unsigned UnusedRasDepth = RAS_DEPTH;
  assign unused_ras = if_stall;
`endif

  // ---------------------------------------------------------------------------
  // Combinational prediction.
  // ---------------------------------------------------------------------------
  always_comb begin
    pred_taken  = 1'b0;
    pred_target = pc_plus4;
    pred_cti    = 1'b0;
    if (if_valid) begin
      case (opcode)
        OpcJal: begin
          pred_cti    = 1'b1;
          pred_taken  = 1'b1;
          pred_target = if_pc + j_imm;
        end
        OpcBranch: begin
          pred_cti = 1'b1;
          if (bht_q[if_idx][1]) begin
            pred_taken  = 1'b1;
            pred_target = if_pc + b_imm;
          end
        end
        OpcJalr: begin
          pred_cti = 1'b1;
`ifdef BRANCH_PREDICTOR_RAS_EN
          if (is_ret && !ras_empty) begin
            pred_taken  = 1'b1;
            pred_target = ras_top;
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (default parameters).
module tb_branch_predictor;

  localparam int unsigned XLEN = 32;

  localparam logic [31:0] InsBeq20  = 32'h0200_0063; // beq x0,x0,+0x20
  localparam logic [31:0] InsJalM8  = 32'hFF9F_F06F; // jal x0,-8
  localparam logic [31:0] InsCall8  = 32'h0080_00EF; // jal x1,+8
  localparam logic [31:0] InsRet    = 32'h0000_8067; // jalr x0,0(x1)
  localparam logic [31:0] InsAddi   = 32'h0000_0013; // addi x0,x0,0

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            if_valid = 1'b0;
  logic            if_stall = 1'b0;
  logic [XLEN-1:0] if_pc = '0;
  logic [31:0]     if_instr = '0;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            pred_cti;
  logic            ex_valid = 1'b0;
  logic            ex_b_type = 1'b0;
  logic [XLEN-1:0] ex_pc = '0;
  logic            ex_taken = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  branch_predictor dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .if_valid    (if_valid),
    .if_stall    (if_stall),
    .if_pc       (if_pc),
    .if_instr    (if_instr),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .pred_cti    (pred_cti),
    .ex_valid    (ex_valid),
    .ex_b_type   (ex_b_type),
    .ex_pc       (ex_pc),
    .ex_taken    (ex_taken)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_pred(input string tag, input logic cti, input logic taken,
                            input logic [31:0] target);
    check_eq({tag, ".cti"}, 32'(pred_cti), 32'(cti));
    check_eq({tag, ".taken"}, 32'(pred_taken), 32'(taken));
    check_eq({tag, ".target"}, pred_target, target);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] instr);
    if_valid = 1'b1;
    if_pc    = pc;
    if_instr = instr;
    #1;
  endtask

  task automatic idle();
    if_valid = 1'b0;
    if_stall = 1'b0;
  endtask

  task automatic update(input logic [31:0] pc, input logic taken, input logic btype);
    ex_valid  = 1'b1;
    ex_b_type = btype;
    ex_pc     = pc;
    ex_taken  = taken;
    step();
    ex_valid  = 1'b0;
  endtask

  initial begin
    // Reset state, observed while reset is held.
    #1;
    fetch(32'h100, InsBeq20);
    check_pred("rst_beq", 1'b1, 1'b0, 32'h104);
    idle();
    step();
    step();
    rst_n = 1'b1;

    // Weakly not-taken after reset.
    fetch(32'h100, InsBeq20);
    check_pred("beq_init", 1'b1, 1'b0, 32'h104);
    idle();

    // Two taken updates -> taken, then saturation at strongly-taken.
    update(32'h100, 1'b1, 1'b1);
    update(32'h100, 1'b1, 1'b1);
    fetch(32'h100, InsBeq20);
    check_pred("beq_2t", 1'b1, 1'b1, 32'h120);
    idle();
    update(32'h100, 1'b1, 1'b1);
    update(32'h100, 1'b1, 1'b1);
    update(32'h100, 1'b0, 1'b1);
    fetch(32'h100, InsBeq20);
    check_pred("beq_sat_1nt", 1'b1, 1'b1, 32'h120);
    idle();
    update(32'h100, 1'b0, 1'b1);
    fetch(32'h100, InsBeq20);
    check_pred("beq_2nt", 1'b1, 1'b0, 32'h104);
    idle();

    // Non-B resolutions leave the counters alone.
    update(32'h180, 1'b1, 1'b0);
    update(32'h180, 1'b1, 1'b0);
    fetch(32'h180, InsBeq20);
    check_pred("nonb_upd", 1'b1, 1'b0, 32'h184);
    idle();

    // jal targets, including wrap below zero, and if_valid gating.
    fetch(32'h200, InsJalM8);
    check_pred("jal", 1'b1, 1'b1, 32'h1F8);
    fetch(32'h4, InsJalM8);
    check_pred("jal_wrap", 1'b1, 1'b1, 32'hFFFF_FFFC);
    if_valid = 1'b0;
    #1;
    check_pred("jal_invalid", 1'b0, 1'b0, 32'h8);

    // Non-CTI and plain jalr.
    fetch(32'h500, InsAddi);
    check_pred("addi", 1'b0, 1'b0, 32'h504);
    fetch(32'h500, InsRet);
    check_pred("jalr_empty", 1'b1, 1'b0, 32'h504);
    idle();

    // Same-cycle update and fetch of one index: old value now, new value next cycle.
    ex_valid  = 1'b1;
    ex_b_type = 1'b1;
    ex_pc     = 32'h140;
    ex_taken  = 1'b1;
    fetch(32'h140, InsBeq20);
    check_pred("same_old", 1'b1, 1'b0, 32'h144);
    step();
    ex_valid = 1'b0;
    #1;
    check_pred("same_new", 1'b1, 1'b1, 32'h160);
    idle();

    // Asynchronous reset mid-run with an in-flight update.
    #2;
    rst_n     = 1'b0;
    ex_valid  = 1'b1;
    ex_b_type = 1'b1;
    ex_pc     = 32'h100;
    ex_taken  = 1'b1;
    fetch(32'h140, InsBeq20);
    check_pred("async_rst", 1'b1, 1'b0, 32'h144);
    idle();
    step();
    ex_valid = 1'b0;
    rst_n    = 1'b1;
    fetch(32'h140, InsBeq20);
    check_pred("post_rst_140", 1'b1, 1'b0, 32'h144);
    fetch(32'h100, InsBeq20);
    check_pred("post_rst_100", 1'b1, 1'b0, 32'h104);
    idle();

`ifdef BRANCH_PREDICTOR_RAS_EN
    // Call then return.
    fetch(32'h300, InsCall8);
    check_pred("call", 1'b1, 1'b1, 32'h308);
    step();
    fetch(32'h308, InsRet);
    check_pred("ret", 1'b1, 1'b1, 32'h304);
    step();
    idle();

    // RAS_DEPTH+1 calls overwrite the oldest; the last return finds the stack empty.
    for (int k = 0; k < 9; k++) begin
      fetch(32'h400 + 32'(k) * 32'h10, InsCall8);
      step();
    end
    for (int k = 0; k < 9; k++) begin
      fetch(32'h800, InsRet);
      if (k < 8) check_pred($sformatf("ovf_ret%0d", k), 1'b1, 1'b1,
                            32'h404 + 32'(8 - k) * 32'h10);
      else check_pred("ovf_ret_last", 1'b1, 1'b0, 32'h804);
      step();
    end
    idle();

    // Stalled call still predicts but does not push.
    if_stall = 1'b1;
    fetch(32'h300, InsCall8);
    check_pred("call_stall", 1'b1, 1'b1, 32'h308);
    step();
    idle();
    fetch(32'h308, InsRet);
    check_pred("ret_after_stall", 1'b1, 1'b0, 32'h30C);
    idle();
`else
    // Without the stack a return is never redirected.
    fetch(32'h300, InsCall8);
    check_pred("call", 1'b1, 1'b1, 32'h308);
    step();
    fetch(32'h308, InsRet);
    check_pred("ret_no_ras", 1'b1, 1'b0, 32'h30C);
    idle();
`endif

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
